rand_gen_bank: RTL and testbench

Multi-channel, parametrised pseudo-random source, successor to the fixed 16-bit/8-bit generator. It holds CHANNELS independent Galois LFSRs of LFSR_W bits. Each produced sample advances every channel by OUT_W single-bit steps in one clock. Samples are delivered through a one-entry valid/ready output register, so stochastic-spike and weight-dither consumers can apply backpressure without losing or duplicating values.

---
 rtl/rand_gen_bank.sv | 114 +++++++++++
 tb/tb_rand_gen_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rand_gen_bank.sv
// Multi-channel Galois LFSR bank: each sample advances every channel OUT_W steps,
// delivered through a one-entry valid/ready output register with an accept counter.

module rand_gen_bank_lane #(
  parameter int                LFSR_W = 16,
  parameter int                OUT_W  = 8,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] INIT   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [OUT_W-1:0]  sample_o
);
  localparam logic [LFSR_W-1:0] INIT_G = (INIT == '0) ? LFSR_W'(1) : INIT;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, stepped;

  always_comb begin
    stepped = lfsr_q;
    for (int i = 0; i < OUT_W; i++)
      stepped = stepped[0] ? ((stepped >> 1) ^ TAPS) : (stepped >> 1);
    lfsr_d = lfsr_q;
    if (load_i)     lfsr_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
    else if (adv_i) lfsr_d = stepped;
  end

  assign sample_o = stepped[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= INIT_G;
    else     lfsr_q <= lfsr_d;
  end
endmodule

module rand_gen_bank #(
  parameter int                LFSR_W     = 16,
  parameter int                OUT_W      = 8,
  parameter int                CHANNELS   = 4,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1,
  parameter int                CNT_W      = 16,
  localparam int               SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      set_seed_i,
  input  logic [SEL_W-1:0]          seed_ch_i,
  input  logic [LFSR_W-1:0]         seed_i,
  input  logic                      rand_ready_i,
  output logic                      rand_valid_o,
  output logic [CHANNELS*OUT_W-1:0] rand_o,
  output logic [CNT_W-1:0]          cnt_o
);
  logic                               fire, adv;
  logic [CHANNELS-1:0][OUT_W-1:0]     smp;
  logic                               valid_q, valid_d;
  logic [CHANNELS*OUT_W-1:0]          rand_q, rand_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;

  assign fire = valid_q && rand_ready_i;
  // A seed cycle suppresses advancing so the next sample comes from the new state.
  assign adv  = !set_seed_i && en_i && (!valid_q || rand_ready_i);

  // Out-of-range channel selects match no lane and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    rand_gen_bank_lane #(
      .LFSR_W (LFSR_W),
      .OUT_W  (OUT_W),
      .TAPS   (TAPS),
      .INIT   (RESET_SEED ^ LFSR_W'(g))
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (adv),
      .load_i   (set_seed_i && (seed_ch_i == SEL_W'(g))),
      .seed_i   (seed_i),
      .sample_o (smp[g])
    );
  end

  always_comb begin
    valid_d = valid_q;
    rand_d  = rand_q;
    cnt_d   = cnt_q + CNT_W'(fire);
    if (set_seed_i) begin
      valid_d = valid_q && !fire;
    end else if (adv) begin
      valid_d = 1'b1;
      rand_d  = smp;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rand_q  <= rand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rand_valid_o = valid_q;
  assign rand_o       = rand_q;
  assign cnt_o        = cnt_q;
endmodule

// File: tb/tb_rand_gen_bank.sv
// Scoreboard bench for rand_gen_bank: driver updates a spec-level model and queues
// expected samples; a negedge monitor checks valid, count and held/accepted samples.

module tb_rand_gen_bank;
  localparam int          LW    = 16;
  localparam int          OW    = 8;
  localparam int          CH    = 3;
  localparam int          CW    = 4;
  localparam int unsigned TAPS  = 32'hB400;
  localparam int unsigned RSEED = 32'hACE1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en_i = 1'b0;
  logic              set_seed_i = 1'b0;
  logic [1:0]        seed_ch_i = '0;
  logic [LW-1:0]     seed_i = '0;
  logic              rand_ready_i = 1'b0;
  logic              rand_valid_o;
  logic [CH*OW-1:0]  rand_o;
  logic [CW-1:0]     cnt_o;

  int total = 0;
  int bad   = 0;

  int unsigned       st [CH];
  bit                m_valid = 1'b0;
  int unsigned       m_cnt = 0;
  logic [CH*OW-1:0]  q [$];

  rand_gen_bank #(
    .LFSR_W(LW), .OUT_W(OW), .CHANNELS(CH),
    .TAPS(16'hB400), .RESET_SEED(16'hACE1), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .set_seed_i   (set_seed_i),
    .seed_ch_i    (seed_ch_i),
    .seed_i       (seed_i),
    .rand_ready_i (rand_ready_i),
    .rand_valid_o (rand_valid_o),
    .rand_o       (rand_o),
    .cnt_o        (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned guard(input int unsigned s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int unsigned advance(input int unsigned s);
    int unsigned v = s;
    repeat (OW) v = (v % 2 == 1) ? ((v / 2) ^ TAPS) : (v / 2);
    return v;
  endfunction

  // Apply one cycle of inputs, then step the reference model with them.
  task automatic cyc(input bit r, input bit e, input bit ss, input int sch,
                     input int unsigned sd, input bit rd);
    bit fire;
    logic [CH*OW-1:0] exp;
    rst = r; en_i = e; set_seed_i = ss; seed_ch_i = sch[1:0];
    seed_i = sd[LW-1:0]; rand_ready_i = rd;
    @(posedge clk); #1;
    fire = m_valid && rd;
    if (r) begin
      for (int c = 0; c < CH; c++) st[c] = guard((RSEED ^ c) & 32'hFFFF);
      m_valid = 1'b0;
      m_cnt   = 0;
      q.delete();
    end else begin
      if (fire) m_cnt = (m_cnt + 1) % (1 << CW);
      if (ss) begin
        if (sch < CH) st[sch] = guard(sd & 32'hFFFF);
        if (fire) m_valid = 1'b0;
      end else if (e && (!m_valid || rd)) begin
        exp = '0;
        for (int c = 0; c < CH; c++) begin
          st[c] = advance(st[c]);
          exp[c*OW +: OW] = st[c][OW-1:0];
        end
        q.push_back(exp);
        m_valid = 1'b1;
      end else if (fire) begin
        m_valid = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", rand_valid_o, m_valid);
      chk("cnt", cnt_o, m_cnt);
      if (m_valid && q.size() > 0) begin
        chk("sample", rand_o, q[0]);
        if (rand_ready_i) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [CH*OW-1:0] held;
    logic [CW-1:0]    held_cnt;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_valid", rand_valid_o, 0);
    chk("rst_rand", rand_o, 0);
    chk("rst_cnt", cnt_o, 0);

    cyc(0, 1, 0, 0, 0, 1);
    chk("first_valid", rand_valid_o, 1);
    chk("first_ch0", rand_o[7:0], 8'hC4);
    cyc(0, 0, 0, 0, 0, 1);
    chk("first_cnt", cnt_o, 1);

    cyc(0, 0, 1, 2, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("zero_seed_ch2", rand_o[23:16], 8'h68);

    held = rand_o; held_cnt = cnt_o;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("bp_hold", rand_o, held);
    end
    chk("bp_cnt", cnt_o, held_cnt);
    cyc(0, 1, 0, 0, 0, 1);

    held_cnt = cnt_o;
    cyc(0, 1, 1, 1, 32'h1234, 1);
    chk("seed_fire_valid", rand_valid_o, 0);
    chk("seed_fire_cnt", cnt_o, (held_cnt + 1) % 16);
    cyc(0, 1, 0, 0, 0, 1);

    cyc(0, 0, 1, 3, 32'h5555, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1);

    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0, 0, 1);
    chk("cnt_wrap", cnt_o, 1);

    cyc(1, 1, 0, 0, 0, 1);
    chk("mid_rst_valid", rand_valid_o, 0);
    chk("mid_rst_rand", rand_o, 0);
    chk("mid_rst_cnt", cnt_o, 0);
    cyc(0, 1, 0, 0, 0, 1);
    chk("post_rst_ch0", rand_o[7:0], 8'hC4);

    for (int i = 0; i < 600; i++) begin
      int unsigned sd;
      sd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 16'hFFFF);
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 8,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3),
          sd,
          $urandom_range(0, 9) < 6);
    end

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
